reorder_buffer: RTL and testbench



---
 rtl/reorder_buffer_pkg.sv | 39 +++
 rtl/reorder_buffer.sv | 203 ++++++++++++++++++++
 tb/tb_reorder_buffer.sv | 305 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/reorder_buffer_pkg.sv
// Shared sizing, tag helpers and slot layout for the reorder buffer.
package reorder_buffer_pkg;

    localparam int ENTRY_SIZE = 4;
    localparam int DEPTH      = 1 << ENTRY_SIZE;

    typedef logic [ENTRY_SIZE:0]   tag_t;
    typedef logic [ENTRY_SIZE-1:0] idx_t;

    localparam tag_t ENTRY_NULL = '0;
    localparam tag_t FULL_COUNT = tag_t'(DEPTH);

    typedef struct packed {
        logic        busy;
        logic        ready;
        logic        is_branch;
        logic        is_store;
        logic        pred_taken;
        logic        taken;
        logic [5:0]  rd;
        logic [31:0] pc;
        logic [31:0] value;
        logic [31:0] target;
    } slot_t;

    // Slot i carries tag i+1 so that tag 0 can mean "no producer".
    function automatic tag_t idx_to_tag(input idx_t idx);
        return tag_t'(idx) + tag_t'(1);
    endfunction

    function automatic idx_t tag_to_idx(input tag_t tag);
        return idx_t'(tag - tag_t'(1));
    endfunction

    function automatic logic tag_in_range(input tag_t tag);
        return (tag != ENTRY_NULL) && (tag <= FULL_COUNT);
    endfunction

endpackage

// File: rtl/reorder_buffer.sv
// Circular in-order retirement buffer: one commit per cycle, registered commit/rollback one edge after the head becomes ready.
// Backpressure: rob_full blocks issue; rdy_in low freezes all state and suppresses the commit/rollback pulses.
module reorder_buffer
    import reorder_buffer_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_in,
    input  logic                  rdy_in,
    input  logic                  issue_valid,
    input  logic [5:0]            issue_rd,
    input  logic                  issue_is_branch,
    input  logic                  issue_is_store,
    input  logic [31:0]           issue_pc,
    input  logic                  issue_pred_taken,
    output logic                  rob_full,
    output logic [ENTRY_SIZE:0]   rob_new_entry,
    input  logic                  alu_valid,
    input  logic [ENTRY_SIZE:0]   alu_entry,
    input  logic [31:0]           alu_value,
    input  logic                  alu_taken,
    input  logic [31:0]           alu_target,
    input  logic                  lsb_valid,
    input  logic [ENTRY_SIZE:0]   lsb_entry,
    input  logic [31:0]           lsb_value,
    input  logic [ENTRY_SIZE:0]   qj_entry,
    input  logic [ENTRY_SIZE:0]   qk_entry,
    output logic                  qj_ready,
    output logic                  qk_ready,
    output logic [31:0]           qj_value,
    output logic [31:0]           qk_value,
    output logic                  rob_commit,
    output logic [ENTRY_SIZE:0]   rob_entry,
    output logic [5:0]            rob_des,
    output logic [31:0]           rob_result,
    output logic                  store_commit,
    output logic                  roll_back,
    output logic [31:0]           roll_back_pc
);

    slot_t slot_q [DEPTH];
    slot_t slot_d [DEPTH];

    idx_t  head_q,  head_d;
    idx_t  tail_q,  tail_d;
    tag_t  count_q, count_d;

    logic        commit_q,    commit_d;
    tag_t        entry_q,     entry_d;
    logic [5:0]  des_q,       des_d;
    logic [31:0] result_q,    result_d;
    logic        store_q,     store_d;
    logic        roll_back_q, roll_back_d;
    logic [31:0] rb_pc_q,     rb_pc_d;

    slot_t head_slot;
    idx_t  alu_idx, lsb_idx, qj_idx, qk_idx;
    logic  alu_hit, lsb_hit;
    logic  commit_fire, mispredict, issue_fire;

    assign head_slot = slot_q[head_q];
    assign alu_idx   = tag_to_idx(alu_entry);
    assign lsb_idx   = tag_to_idx(lsb_entry);
    assign qj_idx    = tag_to_idx(qj_entry);
    assign qk_idx    = tag_to_idx(qk_entry);

    assign alu_hit = alu_valid && tag_in_range(alu_entry) && slot_q[alu_idx].busy;
    assign lsb_hit = lsb_valid && tag_in_range(lsb_entry) && slot_q[lsb_idx].busy;

    assign rob_full      = (count_q == FULL_COUNT);
    assign rob_new_entry = idx_to_tag(tail_q);

    assign commit_fire = rdy_in && (count_q != '0) && head_slot.busy && head_slot.ready;
    assign mispredict  = commit_fire && head_slot.is_branch && (head_slot.taken != head_slot.pred_taken);
    // Issue is squashed both on the flushing edge and during the cycle the flush is visible.
    assign issue_fire  = rdy_in && issue_valid && !rob_full && !roll_back_q && !mispredict;

    always_comb begin
        slot_d      = slot_q;
        head_d      = head_q;
        tail_d      = tail_q;
        count_d     = count_q;
        commit_d    = 1'b0;
        entry_d     = ENTRY_NULL;
        des_d       = '0;
        result_d    = '0;
        store_d     = 1'b0;
        roll_back_d = 1'b0;
        rb_pc_d     = '0;

        if (rdy_in) begin
            if (lsb_hit) begin
                slot_d[lsb_idx].ready = 1'b1;
                slot_d[lsb_idx].value = lsb_value;
            end
            if (alu_hit) begin
                slot_d[alu_idx].ready  = 1'b1;
                slot_d[alu_idx].value  = alu_value;
                slot_d[alu_idx].taken  = alu_taken;
                slot_d[alu_idx].target = alu_target;
            end

            if (commit_fire) begin
                slot_d[head_q].busy  = 1'b0;
                slot_d[head_q].ready = 1'b0;
                head_d   = head_q + 1'b1;
                commit_d = 1'b1;
                entry_d  = idx_to_tag(head_q);
                des_d    = head_slot.rd;
                result_d = head_slot.value;
                store_d  = head_slot.is_store;
            end

            if (issue_fire) begin
                slot_d[tail_q] = '{busy:       1'b1,
                                   ready:      1'b0,
                                   is_branch:  issue_is_branch,
                                   is_store:   issue_is_store,
                                   pred_taken: issue_pred_taken,
                                   taken:      1'b0,
                                   rd:         issue_rd,
                                   pc:         issue_pc,
                                   value:      32'd0,
                                   target:     32'd0};
                tail_d = tail_q + 1'b1;
            end

            case ({issue_fire, commit_fire})
                2'b10:   count_d = count_q + tag_t'(1);
                2'b01:   count_d = count_q - tag_t'(1);
                default: count_d = count_q;
            endcase

            // The committing branch still retires; everything younger is discarded.
            if (mispredict) begin
                for (int i = 0; i < DEPTH; i++) begin
                    slot_d[i].busy  = 1'b0;
                    slot_d[i].ready = 1'b0;
                end
                head_d      = '0;
                tail_d      = '0;
                count_d     = '0;
                roll_back_d = 1'b1;
                rb_pc_d     = head_slot.taken ? head_slot.target : head_slot.pc + 32'd4;
            end
        end
    end

    always_comb begin
        qj_ready = 1'b0;
        qj_value = '0;
        qk_ready = 1'b0;
        qk_value = '0;
        if (tag_in_range(qj_entry) && slot_q[qj_idx].busy && slot_q[qj_idx].ready) begin
            qj_ready = 1'b1;
            qj_value = slot_q[qj_idx].value;
        end
        if (tag_in_range(qk_entry) && slot_q[qk_idx].busy && slot_q[qk_idx].ready) begin
            qk_ready = 1'b1;
            qk_value = slot_q[qk_idx].value;
        end
    end

    always_ff @(posedge clk or posedge rst_in) begin
        if (rst_in) begin
            for (int i = 0; i < DEPTH; i++) begin
                slot_q[i] <= '0;
            end
            head_q      <= '0;
            tail_q      <= '0;
            count_q     <= '0;
            commit_q    <= 1'b0;
            entry_q     <= ENTRY_NULL;
            des_q       <= '0;
            result_q    <= '0;
            store_q     <= 1'b0;
            roll_back_q <= 1'b0;
            rb_pc_q     <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                slot_q[i] <= slot_d[i];
            end
            head_q      <= head_d;
            tail_q      <= tail_d;
            count_q     <= count_d;
            commit_q    <= commit_d;
            entry_q     <= entry_d;
            des_q       <= des_d;
            result_q    <= result_d;
            store_q     <= store_d;
            roll_back_q <= roll_back_d;
            rb_pc_q     <= rb_pc_d;
        end
    end

    assign rob_commit   = commit_q & rdy_in;
    assign store_commit = store_q & rdy_in;
    assign roll_back    = roll_back_q & rdy_in;
    assign rob_entry    = entry_q;
    assign rob_des      = des_q;
    assign rob_result   = result_q;
    assign roll_back_pc = rb_pc_q;

endmodule

// File: tb/tb_reorder_buffer.sv
// Directed bench for reorder_buffer: commits are matched in order against a scoreboard of expected retirements.
module tb_reorder_buffer;
    import reorder_buffer_pkg::*;

    localparam logic [5:0] RD_NULL = 6'b100000;

    logic        clk, rst_in, rdy_in;
    logic        issue_valid, issue_is_branch, issue_is_store, issue_pred_taken;
    logic [5:0]  issue_rd;
    logic [31:0] issue_pc;
    logic        rob_full;
    logic [4:0]  rob_new_entry;
    logic        alu_valid, alu_taken;
    logic [4:0]  alu_entry;
    logic [31:0] alu_value, alu_target;
    logic        lsb_valid;
    logic [4:0]  lsb_entry;
    logic [31:0] lsb_value;
    logic [4:0]  qj_entry, qk_entry;
    logic        qj_ready, qk_ready;
    logic [31:0] qj_value, qk_value;
    logic        rob_commit, store_commit, roll_back;
    logic [4:0]  rob_entry;
    logic [5:0]  rob_des;
    logic [31:0] rob_result, roll_back_pc;

    reorder_buffer dut (
        .clk(clk), .rst_in(rst_in), .rdy_in(rdy_in),
        .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_is_branch(issue_is_branch),
        .issue_is_store(issue_is_store), .issue_pc(issue_pc), .issue_pred_taken(issue_pred_taken),
        .rob_full(rob_full), .rob_new_entry(rob_new_entry),
        .alu_valid(alu_valid), .alu_entry(alu_entry), .alu_value(alu_value),
        .alu_taken(alu_taken), .alu_target(alu_target),
        .lsb_valid(lsb_valid), .lsb_entry(lsb_entry), .lsb_value(lsb_value),
        .qj_entry(qj_entry), .qk_entry(qk_entry), .qj_ready(qj_ready), .qk_ready(qk_ready),
        .qj_value(qj_value), .qk_value(qk_value),
        .rob_commit(rob_commit), .rob_entry(rob_entry), .rob_des(rob_des), .rob_result(rob_result),
        .store_commit(store_commit), .roll_back(roll_back), .roll_back_pc(roll_back_pc)
    );

    typedef struct {
        logic [4:0]  tag;
        logic [5:0]  rd;
        logic [31:0] res;
        logic        st;
        logic        rb;
        logic [31:0] rb_pc;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input logic [4:0] tag, input logic [5:0] rd, input logic [31:0] res,
                            input logic st, input logic rb, input logic [31:0] rb_pc);
        exp_t e;
        e.tag = tag; e.rd = rd; e.res = res; e.st = st; e.rb = rb; e.rb_pc = rb_pc;
        sb.push_back(e);
    endtask

    // Every commit pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!rst_in && rob_commit) begin
            checks++;
            assert (sb.size() != 0) else begin
                errors++;
                $error("FAIL unexpected_commit observed_tag=%0h expected=none", rob_entry);
            end
            if (sb.size() != 0) begin
                exp_t e;
                e = sb.pop_front();
                check("sb_tag", 32'(rob_entry), 32'(e.tag));
                check("sb_des", 32'(rob_des), 32'(e.rd));
                check("sb_result", rob_result, e.res);
                check("sb_store", 32'(store_commit), 32'(e.st));
                check("sb_roll_back", 32'(roll_back), 32'(e.rb));
                if (e.rb) check("sb_roll_back_pc", roll_back_pc, e.rb_pc);
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_issue(input logic [5:0] rd, input logic br, input logic st,
                            input logic [31:0] pc, input logic pred);
        issue_valid = 1'b1; issue_rd = rd; issue_is_branch = br;
        issue_is_store = st; issue_pc = pc; issue_pred_taken = pred;
        tick;
        issue_valid = 1'b0; issue_is_branch = 1'b0; issue_is_store = 1'b0;
    endtask

    task automatic alu_wb(input logic [4:0] tag, input logic [31:0] val,
                          input logic taken, input logic [31:0] target);
        alu_valid = 1'b1; alu_entry = tag; alu_value = val; alu_taken = taken; alu_target = target;
        tick;
        alu_valid = 1'b0;
    endtask

    task automatic lsb_wb(input logic [4:0] tag, input logic [31:0] val);
        lsb_valid = 1'b1; lsb_entry = tag; lsb_value = val;
        tick;
        lsb_valid = 1'b0;
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while (sb.size() != 0 && n < budget) begin
            tick;
            n++;
        end
        tick;
        checks++;
        assert (sb.size() == 0) else begin
            errors++;
            $error("FAIL drain observed_pending=%0d expected=0", sb.size());
        end
    endtask

    initial begin
        rst_in = 1'b1; rdy_in = 1'b1;
        issue_valid = 1'b0; issue_rd = '0; issue_is_branch = 1'b0; issue_is_store = 1'b0;
        issue_pc = '0; issue_pred_taken = 1'b0;
        alu_valid = 1'b0; alu_entry = '0; alu_value = '0; alu_taken = 1'b0; alu_target = '0;
        lsb_valid = 1'b0; lsb_entry = '0; lsb_value = '0;
        qj_entry = '0; qk_entry = '0;
        #2;
        check("rst_commit", 32'(rob_commit), 0);
        check("rst_roll_back", 32'(roll_back), 0);
        check("rst_new_entry", 32'(rob_new_entry), 1);
        check("rst_full", 32'(rob_full), 0);
        check("null_lookup_ready", 32'(qj_ready), 0);
        check("null_lookup_value", qj_value, 0);
        repeat (2) @(posedge clk);
        #1 rst_in = 1'b0;

        // Single issue / write-back / commit latency
        check("basic_new_tag", 32'(rob_new_entry), 1);
        do_issue(6'd5, 1'b0, 1'b0, 32'h1000, 1'b0);
        check("basic_tag_advance", 32'(rob_new_entry), 2);
        push_exp(5'd1, 6'd5, 32'h1234, 1'b0, 1'b0, 32'h0);
        alu_wb(5'd1, 32'h1234, 1'b0, 32'h0);
        check("basic_no_bypass", 32'(rob_commit), 0);
        tick;
        check("basic_commit", 32'(rob_commit), 1);
        check("basic_entry", 32'(rob_entry), 1);
        check("basic_des", 32'(rob_des), 5);
        check("basic_result", rob_result, 32'h1234);
        tick;
        check("basic_pulse_once", 32'(rob_commit), 0);
        check("basic_result_cleared", rob_result, 0);

        // Asynchronous reset with live entries
        for (int i = 1; i <= 4; i++) do_issue(6'(i), 1'b0, 1'b0, 32'h1100 + 32'(i * 4), 1'b0);
        push_exp(5'd2, 6'd1, 32'hAA, 1'b0, 1'b0, 32'h0);
        alu_wb(5'd2, 32'hAA, 1'b0, 32'h0);
        tick;
        check("pre_rst_commit", 32'(rob_commit), 1);
        #5 rst_in = 1'b1;
        #1;
        check("async_rst_commit", 32'(rob_commit), 0);
        check("async_rst_entry", 32'(rob_entry), 0);
        check("async_rst_result", rob_result, 0);
        check("async_rst_new_entry", 32'(rob_new_entry), 1);
        @(posedge clk);
        #1 rst_in = 1'b0;
        lsb_wb(5'd3, 32'h33);
        alu_wb(5'd4, 32'h44, 1'b0, 32'h0);
        qj_entry = 5'd3;
        #1 check("flushed_lookup", 32'(qj_ready), 0);
        repeat (3) tick;
        check("no_commit_after_rst", 32'(rob_commit), 0);

        // Fill to capacity, overflow issue, wrap of tag 1
        for (int i = 0; i < 16; i++) do_issue(6'(i), 1'b0, (i == 3), 32'h2000 + 32'(i * 4), 1'b0);
        check("full_set", 32'(rob_full), 1);
        check("full_new_entry_wrap", 32'(rob_new_entry), 1);
        do_issue(6'd31, 1'b0, 1'b0, 32'h3000, 1'b0);
        check("overflow_ignored_full", 32'(rob_full), 1);
        check("overflow_ignored_tag", 32'(rob_new_entry), 1);
        push_exp(5'd1, 6'd0, 32'hA0, 1'b0, 1'b0, 32'h0);
        lsb_wb(5'd1, 32'hA0);
        check("full_before_commit", 32'(rob_full), 1);
        do_issue(6'd20, 1'b0, 1'b0, 32'h3004, 1'b0);
        check("full_commit_edge", 32'(rob_commit), 1);
        check("same_cycle_issue_blocked", 32'(rob_new_entry), 1);
        check("full_released", 32'(rob_full), 0);
        do_issue(6'd21, 1'b0, 1'b0, 32'h3008, 1'b0);
        check("tag1_reused", 32'(rob_new_entry), 2);
        check("full_again", 32'(rob_full), 1);
        for (int t = 2; t <= 16; t++) begin
            push_exp(5'(t), 6'(t - 1), 32'h300 + 32'(t), (t == 4), 1'b0, 32'h0);
            if (t % 2 == 1) lsb_wb(5'(t), 32'h300 + 32'(t));
            else alu_wb(5'(t), 32'h300 + 32'(t), 1'b0, 32'h0);
        end
        push_exp(5'd1, 6'd21, 32'h999, 1'b0, 1'b0, 32'h0);
        alu_wb(5'd1, 32'h999, 1'b0, 32'h0);
        drain(40);

        // Out-of-order completion, in-order retirement
        rst_in = 1'b1; tick; rst_in = 1'b0;
        do_issue(6'd7, 1'b0, 1'b0, 32'h4000, 1'b0);
        do_issue(6'd8, 1'b0, 1'b0, 32'h4004, 1'b0);
        do_issue(6'd9, 1'b0, 1'b0, 32'h4008, 1'b0);
        push_exp(5'd1, 6'd7, 32'h11, 1'b0, 1'b0, 32'h0);
        push_exp(5'd2, 6'd8, 32'h22, 1'b0, 1'b0, 32'h0);
        push_exp(5'd3, 6'd9, 32'h33, 1'b0, 1'b0, 32'h0);
        alu_wb(5'd3, 32'h33, 1'b0, 32'h0);
        qj_entry = 5'd3; qk_entry = 5'd1;
        #1;
        check("ooo_qj_ready", 32'(qj_ready), 1);
        check("ooo_qj_value", qj_value, 32'h33);
        check("ooo_qk_not_ready", 32'(qk_ready), 0);
        check("ooo_qk_value_zero", qk_value, 0);
        check("ooo_no_early_commit", 32'(rob_commit), 0);
        lsb_wb(5'd1, 32'h11);
        check("ooo_qk_ready_now", 32'(qk_ready), 1);
        alu_wb(5'd2, 32'h22, 1'b0, 32'h0);
        check("ooo_first", 32'(rob_entry), 1);
        tick;
        check("ooo_second", 32'(rob_entry), 2);
        tick;
        check("ooo_third", 32'(rob_entry), 3);
        tick;
        check("ooo_done", 32'(rob_commit), 0);
        check("ooo_qj_after_commit", 32'(qj_ready), 0);
        do_issue(6'd12, 1'b0, 1'b0, 32'h400c, 1'b0);
        do_issue(6'd13, 1'b0, 1'b1, 32'h4010, 1'b0);
        push_exp(5'd4, 6'd12, 32'h44, 1'b0, 1'b0, 32'h0);
        push_exp(5'd5, 6'd13, 32'h55, 1'b1, 1'b0, 32'h0);
        alu_valid = 1'b1; alu_entry = 5'd4; alu_value = 32'h44; alu_taken = 1'b0;
        lsb_valid = 1'b1; lsb_entry = 5'd5; lsb_value = 32'h55;
        tick;
        alu_valid = 1'b0; lsb_valid = 1'b0;
        drain(10);

        // Branch mispredict at commit
        rst_in = 1'b1; tick; rst_in = 1'b0;
        do_issue(6'd1, 1'b0, 1'b0, 32'h40, 1'b0);
        do_issue(RD_NULL, 1'b1, 1'b0, 32'h44, 1'b0);
        do_issue(6'd3, 1'b0, 1'b0, 32'h48, 1'b0);
        do_issue(6'd4, 1'b0, 1'b0, 32'h4c, 1'b0);
        push_exp(5'd1, 6'd1, 32'h10, 1'b0, 1'b0, 32'h0);
        push_exp(5'd2, RD_NULL, 32'h48, 1'b0, 1'b1, 32'h100);
        alu_wb(5'd1, 32'h10, 1'b0, 32'h0);
        alu_wb(5'd2, 32'h48, 1'b1, 32'h100);
        issue_valid = 1'b1; issue_rd = 6'd10; issue_pc = 32'h50;
        alu_wb(5'd3, 32'h30, 1'b0, 32'h0);
        issue_valid = 1'b0;
        check("mp_roll_back", 32'(roll_back), 1);
        check("mp_roll_back_pc", roll_back_pc, 32'h100);
        check("mp_commit", 32'(rob_commit), 1);
        check("mp_entry", 32'(rob_entry), 2);
        check("mp_new_entry", 32'(rob_new_entry), 1);
        tick;
        check("mp_pulse_once", 32'(roll_back), 0);
        alu_wb(5'd4, 32'h40, 1'b0, 32'h0);
        qj_entry = 5'd3;
        #1 check("mp_flushed_lookup", 32'(qj_ready), 0);
        repeat (4) tick;
        check("mp_no_young_commit", 32'(rob_commit), 0);
        check("mp_empty_new_entry", 32'(rob_new_entry), 1);

        // Freeze while head is ready
        do_issue(6'd3, 1'b0, 1'b0, 32'h100, 1'b0);
        push_exp(5'd1, 6'd3, 32'h55, 1'b0, 1'b0, 32'h0);
        alu_wb(5'd1, 32'h55, 1'b0, 32'h0);
        rdy_in = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick;
            check("frozen_no_commit", 32'(rob_commit), 0);
        end
        rdy_in = 1'b1;
        tick;
        check("thaw_commit", 32'(rob_commit), 1);
        check("thaw_entry", 32'(rob_entry), 1);
        tick;
        check("thaw_once", 32'(rob_commit), 0);

        drain(10);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
